// File: rtl/party_event_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : party_event_monitor_if
// Purpose  : Bundles the availability input, the event handshake and the
//            status outputs of party_event_monitor.
// Signals  : P        - raw availability signal (driven by the producer side)
//            EvtAck   - consumer acknowledge of the pending event
//            EvtValid - qualified event pending, held until acknowledged
//            Active   - monitor is in ACTIVE or RELEASE
//            EvtCount - qualified events since reset (CNT_W bits, wraps)
//            Overflow - sticky: event raised while previous one unacked
// Modports : master - environment/consumer side
//            slave  - the monitor itself
// Revision : 1.0 - initial release
// ============================================================================
interface party_event_monitor_if #(
  parameter int CNT_W = 8
) ();
  logic             P;
  logic             EvtAck;
  logic             EvtValid;
  logic             Active;
  logic [CNT_W-1:0] EvtCount;
  logic             Overflow;

  modport master (
    output P,
    output EvtAck,
    input  EvtValid,
    input  Active,
    input  EvtCount,
    input  Overflow
  );

  modport slave (
    input  P,
    input  EvtAck,
    output EvtValid,
    output Active,
    output EvtCount,
    output Overflow
  );
endinterface
`default_nettype wire

// File: rtl/party_event_monitor.sv
`default_nettype none
// ============================================================================
// Module   : party_event_monitor
// Purpose  : Glitch-qualifies the availability signal P. P must be high for
//            HOLD_CYCLES consecutive samples to raise a "party" event and low
//            for HOLD_CYCLES consecutive samples to leave the active state.
//            Each event bumps a wrapping counter and is reported through a
//            valid/ack handshake with a sticky overflow flag.
// Ports    : Clk  - rising-edge clock
//            Rst  - synchronous active-high reset
//            bus  - party_event_monitor_if.slave (P, EvtAck in;
//                   EvtValid, Active, EvtCount, Overflow out)
// Options  : PEM_SYNC_EN - when defined, P goes through a 2-flop
//            synchronizer before the FSM (adds 2 edges of latency);
//            when undefined, P must already be synchronous to Clk.
// Revision : 1.0 - initial release
// ============================================================================
module party_event_monitor #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  wire logic            Clk,
  input  wire logic            Rst,
  party_event_monitor_if.slave bus
);

  localparam int QC_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [QC_W-1:0] c_qc_one  = QC_W'(1);
  localparam logic [QC_W-1:0] c_qc_last = QC_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_QUAL    = 2'd1,
    S_ACTIVE  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [QC_W-1:0]   r_qc;
  logic [QC_W-1:0]   w_qc_nxt;
  logic              w_evt;
  logic              w_ps;
  logic              r_active;
  logic              r_valid;
  logic              r_ovf;
  logic [CNT_W-1:0]  r_cnt;

`ifdef PEM_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.P;
      r_sync2 <= r_sync1;
    end
  end

  assign w_ps = r_sync2;
`else
  assign w_ps = bus.P;
`endif

  // qc counts consecutive samples that disagree with the current
  // active/idle level; the HOLD_CYCLES-th such sample flips the level.
  always_comb begin
    w_state_nxt = r_state;
    w_qc_nxt    = r_qc;
    w_evt       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ps) begin
          w_qc_nxt = c_qc_one;
          if (HOLD_CYCLES == 1) begin
            w_state_nxt = S_ACTIVE;
            w_evt       = 1'b1;
          end else begin
            w_state_nxt = S_QUAL;
          end
        end else begin
          w_qc_nxt = '0;
        end
      end
      S_QUAL: begin
        if (!w_ps) begin
          w_state_nxt = S_IDLE;
          w_qc_nxt    = '0;
        end else if (r_qc == c_qc_last) begin
          w_state_nxt = S_ACTIVE;
          w_qc_nxt    = '0;
          w_evt       = 1'b1;
        end else begin
          w_qc_nxt = r_qc + c_qc_one;
        end
      end
      S_ACTIVE: begin
        if (!w_ps) begin
          w_qc_nxt = c_qc_one;
          if (HOLD_CYCLES == 1) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        // A return to high before the hold-off expires is the same event.
        if (w_ps) begin
          w_state_nxt = S_ACTIVE;
          w_qc_nxt    = '0;
        end else if (r_qc == c_qc_last) begin
          w_state_nxt = S_IDLE;
          w_qc_nxt    = '0;
        end else begin
          w_qc_nxt = r_qc + c_qc_one;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_qc_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state  <= S_IDLE;
      r_qc     <= '0;
      r_active <= 1'b0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_qc     <= w_qc_nxt;
      r_active <= (w_state_nxt == S_ACTIVE) || (w_state_nxt == S_RELEASE);
      if (w_evt) begin
        r_cnt   <= r_cnt + CNT_W'(1);
        r_valid <= 1'b1;
        // An ack on the same edge retires the old event, so no overflow.
        if (r_valid && !bus.EvtAck) begin
          r_ovf <= 1'b1;
        end
      end else if (r_valid && bus.EvtAck) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.EvtValid = r_valid;
  assign bus.Active   = r_active;
  assign bus.EvtCount = r_cnt;
  assign bus.Overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_party_event_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_party_event_monitor
// Purpose  : Self-checking bench for party_event_monitor. Two instances share
//            the stimulus: dut0 (HOLD_CYCLES=4, CNT_W=8) and dut1
//            (HOLD_CYCLES=1, CNT_W=2). A run-length reference model predicts
//            the outputs of both.
// Revision : 1.0 - initial release
// ============================================================================
module tb_party_event_monitor;

`ifdef PEM_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int H0 = 4;
  localparam int W0 = 8;
  localparam int H1 = 1;
  localparam int W1 = 2;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic p   = 1'b0;
  logic ack = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  party_event_monitor_if #(.CNT_W(W0)) bus0 ();
  party_event_monitor_if #(.CNT_W(W1)) bus1 ();

  assign bus0.P      = p;
  assign bus0.EvtAck = ack;
  assign bus1.P      = p;
  assign bus1.EvtAck = ack;

  party_event_monitor #(.HOLD_CYCLES(H0), .CNT_W(W0)) dut0 (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus0.slave)
  );

  party_event_monitor #(.HOLD_CYCLES(H1), .CNT_W(W1)) dut1 (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus1.slave)
  );

  // Reference model: level flips after H consecutive disagreeing samples.
  bit m_active [2];
  int m_run    [2];
  bit m_valid  [2];
  bit m_ovf    [2];
  int m_cnt    [2];
  bit m_s1     [2];
  bit m_s2     [2];

  task automatic model_step(input int i);
    int h;
    int w;
    bit ps;
    bit ev;
    h = (i == 0) ? H0 : H1;
    w = (i == 0) ? W0 : W1;
    if (Rst) begin
      m_active[i] = 0; m_run[i] = 0; m_valid[i] = 0; m_ovf[i] = 0;
      m_cnt[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
    end else begin
      if (LAT == 2) begin
        ps = m_s2[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = p;
      end else begin
        ps = p;
      end
      ev = 0;
      if (ps != m_active[i]) begin
        m_run[i]++;
        if (m_run[i] == h) begin
          m_active[i] = ps;
          m_run[i] = 0;
          ev = ps;
        end
      end else begin
        m_run[i] = 0;
      end
      if (ev) begin
        if (m_valid[i] && !ack) m_ovf[i] = 1;
        m_valid[i] = 1;
        m_cnt[i] = (m_cnt[i] + 1) % (1 << w);
      end else if (m_valid[i] && ack) begin
        m_valid[i] = 0;
      end
    end
  endtask

  // Advance one clock: model follows the inputs seen at the rising edge,
  // outputs are then examined at the falling edge.
  task automatic tick();
    @(posedge Clk);
    model_step(0);
    model_step(1);
    @(negedge Clk);
  endtask

  function automatic logic [10:0] got0();
    return {bus0.EvtValid, bus0.Active, bus0.Overflow, bus0.EvtCount};
  endfunction
  function automatic logic [10:0] exp0();
    return {m_valid[0], m_active[0], m_ovf[0], 8'(m_cnt[0])};
  endfunction
  function automatic logic [4:0] got1();
    return {bus1.EvtValid, bus1.Active, bus1.Overflow, bus1.EvtCount};
  endfunction
  function automatic logic [4:0] exp1();
    return {m_valid[1], m_active[1], m_ovf[1], 2'(m_cnt[1])};
  endfunction

  task automatic do_reset();
    Rst = 1'b1; p = 1'b0; ack = 1'b0;
    tick();
    Rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    Rst = 1'b1; p = 1'b0; ack = 1'b0;
    for (int n = 0; n < 2; n++) begin
      tick();
      checks++;
      if (got0() !== 11'd0 || got1() !== 5'd0) begin
        failures++;
        $display("FAIL reset_outputs got0=%h got1=%h required 0", got0(), got1());
      end
    end
    Rst = 1'b0; p = 1'b1;
    for (int n = 1; n <= H0 + LAT + 1; n++) begin
      tick();
      checks++;
      if (got0() !== exp0()) begin
        failures++;
        $display("FAIL entry_model edge=%0d got=%h required=%h", n, got0(), exp0());
      end
      if (n == H0 + LAT - 1) begin
        checks++;
        if (bus0.Active !== 1'b0) begin
          failures++;
          $display("FAIL entry_early edge=%0d Active=%b required 0", n, bus0.Active);
        end
      end
      if (n == H0 + LAT) begin
        checks++;
        if (bus0.Active !== 1'b1 || bus0.EvtValid !== 1'b1 || bus0.EvtCount !== 8'd1) begin
          failures++;
          $display("FAIL entry_latency edge=%0d A/V/C=%b%b%0d required 1 1 1",
                   n, bus0.Active, bus0.EvtValid, bus0.EvtCount);
        end
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int r = 0; r < 5; r++) begin
      for (int t = 0; t < 6; t++) begin
        p = (t < 3);
        tick();
        checks++;
        if (got0() !== exp0() || bus0.Active !== 1'b0) begin
          failures++;
          $display("FAIL glitch r=%0d t=%0d got=%h required=%h", r, t, got0(), exp0());
        end
      end
    end
    checks++;
    if (bus0.EvtCount !== 8'd0 || bus0.EvtValid !== 1'b0) begin
      failures++;
      $display("FAIL glitch_final cnt=%0d valid=%b required 0 0", bus0.EvtCount, bus0.EvtValid);
    end
  endtask

  task automatic test_dropout();
    logic [7:0] c;
    p = 1'b1;
    for (int n = 0; n < H0 + LAT; n++) tick();
    c = bus0.EvtCount;
    for (int t = 0; t < LAT + 6; t++) begin
      p = (t >= 3);
      tick();
      checks++;
      if (got0() !== exp0() || bus0.Active !== 1'b1) begin
        failures++;
        $display("FAIL dropout t=%0d got=%h required=%h", t, got0(), exp0());
      end
    end
    checks++;
    if (bus0.EvtCount !== c || c !== 8'd1) begin
      failures++;
      $display("FAIL dropout_count cnt=%0d required 1", bus0.EvtCount);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int ph = 0; ph < 3; ph++) begin
      p = (ph != 1);
      for (int n = 0; n < H0 + LAT; n++) begin
        tick();
        checks++;
        if (got0() !== exp0()) begin
          failures++;
          $display("FAIL overflow_model ph=%0d n=%0d got=%h required=%h", ph, n, got0(), exp0());
        end
      end
    end
    checks++;
    if (bus0.EvtCount !== 8'd2 || bus0.EvtValid !== 1'b1 || bus0.Overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_set C/V/O=%0d %b %b required 2 1 1",
               bus0.EvtCount, bus0.EvtValid, bus0.Overflow);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (bus0.EvtValid !== 1'b0 || bus0.Overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_ack V/O=%b %b required 0 1", bus0.EvtValid, bus0.Overflow);
    end
  endtask

  task automatic test_wrap();
    int seq [5] = '{1, 2, 3, 0, 1};
    do_reset();
    for (int n = 0; n <= LAT; n++) tick();
    for (int k = 0; k < 5; k++) begin
      p = 1'b1;
      for (int t = 0; t <= LAT; t++) begin
        ack = (k == 4 && t == LAT);
        tick();
        checks++;
        if (got1() !== exp1()) begin
          failures++;
          $display("FAIL wrap_model k=%0d t=%0d got=%h required=%h", k, t, got1(), exp1());
        end
      end
      checks++;
      if (int'(bus1.EvtCount) != seq[k]) begin
        failures++;
        $display("FAIL wrap_count k=%0d cnt=%0d required %0d", k, bus1.EvtCount, seq[k]);
      end
      if (k == 4) begin
        checks++;
        if (bus1.EvtValid !== 1'b1 || bus1.Overflow !== 1'b0) begin
          failures++;
          $display("FAIL wrap_ack_same_edge V/O=%b %b required 1 0", bus1.EvtValid, bus1.Overflow);
        end
      end
      p = 1'b0;
      ack = (k != 3);
      for (int t = 0; t <= LAT; t++) begin
        tick();
        checks++;
        if (got1() !== exp1()) begin
          failures++;
          $display("FAIL wrap_low k=%0d t=%0d got=%h required=%h", k, t, got1(), exp1());
        end
      end
      ack = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    p = 1'b1;
    for (int n = 0; n < LAT + 2; n++) tick();
    Rst = 1'b1;
    tick();
    checks++;
    if (got0() !== 11'd0 || got0() !== exp0()) begin
      failures++;
      $display("FAIL reset_in_qual got=%h required 0", got0());
    end
    Rst = 1'b0;
    for (int n = 1; n <= H0 + LAT; n++) begin
      tick();
      checks++;
      if (bus0.Active !== logic'(n == H0 + LAT) || got0() !== exp0()) begin
        failures++;
        $display("FAIL requal edge=%0d got=%h required=%h", n, got0(), exp0());
      end
    end
    Rst = 1'b1;
    tick();
    checks++;
    if (got0() !== 11'd0 || got1() !== 5'd0) begin
      failures++;
      $display("FAIL reset_in_active got0=%h got1=%h required 0", got0(), got1());
    end
    Rst = 1'b0; p = 1'b0;
  endtask

  task automatic test_random();
    int run;
    do_reset();
    run = 0;
    for (int n = 0; n < 800; n++) begin
      if (run == 0) begin
        p = 1'($urandom_range(0, 1));
        run = $urandom_range(1, 7);
      end
      run--;
      ack = ($urandom_range(0, 3) == 0);
      Rst = ($urandom_range(0, 299) == 0);
      tick();
      checks++;
      if (got0() !== exp0() || got1() !== exp1()) begin
        failures++;
        $display("FAIL random n=%0d got0=%h req0=%h got1=%h req1=%h",
                 n, got0(), exp0(), got1(), exp1());
      end
    end
    Rst = 1'b0; ack = 1'b0;
  endtask

  initial begin
    @(negedge Clk);
    test_reset();
    test_glitch();
    test_dropout();
    test_overflow();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
